// File: rtl/divider_core_if.sv
// Operand/result bundle between the divider register slave and the divider core.
// The master drives the operands and start; the slave returns the results and status.
interface divider_core_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] quotient;
  logic [DATA_WIDTH-1:0] remainder;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/divider_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per clock, new operation
// accepted only while not iterating (IDLE or the DONE cycle).
module divider_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic           ACLK,
  input  logic           ARESET,
  divider_core_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [DATA_WIDTH-1:0]   q_work;
  logic [DATA_WIDTH-1:0]   rem_work;
  logic [DATA_WIDTH-1:0]   divisor_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    dbz_r;
  logic [DATA_WIDTH-1:0]   quotient_r;
  logic [DATA_WIDTH-1:0]   remainder_r;

  logic [DATA_WIDTH:0]     step;
  logic [DATA_WIDTH-1:0]   rem_next;
  logic [DATA_WIDTH-1:0]   q_next;
  logic                    accept;

  // One restoring step: returns {quotient bit, new partial remainder}. The trial
  // subtraction is one bit wider than the operands so its MSB is the borrow.
  // The partial remainder entering a step is always below 2**(W-1), so dropping
  // its MSB in the shift loses nothing.
  function automatic logic [DATA_WIDTH:0] div_step(
    input logic [DATA_WIDTH-1:0] rem,
    input logic                  q_msb,
    input logic [DATA_WIDTH-1:0] dvs
  );
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH:0]   trial;
    shifted = {rem[DATA_WIDTH-2:0], q_msb};
    trial   = {1'b0, shifted} - {1'b0, dvs};
    if (trial[DATA_WIDTH]) begin
      return {1'b0, shifted};
    end
    return {1'b1, trial[DATA_WIDTH-1:0]};
  endfunction

  always_comb begin
    step     = div_step(rem_work, q_work[DATA_WIDTH-1], divisor_r);
    rem_next = step[DATA_WIDTH-1:0];
    q_next   = {q_work[DATA_WIDTH-2:0], step[DATA_WIDTH]};
    accept   = bus.start && (state != S_RUN);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= S_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dbz_r       <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (bus.divisor != '0) begin
              q_work    <= bus.dividend;
              rem_work  <= '0;
              divisor_r <= bus.divisor;
              cnt       <= CNT_W'(DATA_WIDTH - 1);
              dbz_r     <= 1'b0;
              busy_r    <= 1'b1;
              state     <= S_RUN;
            end else begin
              // Divide by zero short-circuits straight to the result cycle.
              quotient_r  <= '1;
              remainder_r <= bus.dividend;
              dbz_r       <= 1'b1;
              done_r      <= 1'b1;
              state       <= S_DONE;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          q_work   <= q_next;
          rem_work <= rem_next;
          cnt      <= cnt - 1'b1;
          if (cnt == '0) begin
            quotient_r  <= q_next;
            remainder_r <= rem_next;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            state       <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;

endmodule

// File: tb/tb_divider_core.sv
// Bench for divider_core: directed vector table, hand-written corner sequences
// and random operations checked against a plain-arithmetic reference model.
module tb_divider_core;

  localparam int W = 32;

  logic ACLK = 1'b0;
  logic ARESET;

  always #5 ACLK = ~ACLK;

  divider_core_if #(.DATA_WIDTH(W)) bus ();

  divider_core #(.DATA_WIDTH(W)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    string        name;
  } vec_t;

  vec_t vecs[6];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Reference: division by the rules of integer arithmetic.
  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dbz);
    if (b == '0) begin
      q = '1; r = a; dbz = 1'b1;
    end else begin
      q = a / b; r = a % b; dbz = 1'b0;
    end
  endtask

  // Called at a negedge (cycle c): drives start for one cycle, follows the
  // operation to its done pulse and checks latency, busy length and results.
  // Optionally pulses a second start at cycle c+pulse_k. Returns at the
  // negedge of the done cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                        input string name, input int pulse_k,
                        input logic [W-1:0] pa, input logic [W-1:0] pb);
    int k;
    int busy_cnt;
    int exp_lat;
    int exp_busy;
    exp_lat  = edbz ? 1 : W + 1;
    exp_busy = edbz ? 0 : W;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge ACLK);
    k = 1;
    busy_cnt = 0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    bus.start    = 1'b0;
    while (!bus.done && k <= W + 4) begin
      if (bus.busy) busy_cnt++;
      if (k == pulse_k) begin
        bus.start = 1'b1; bus.dividend = pa; bus.divisor = pb;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge ACLK);
      k++;
    end
    bus.start = 1'b0;
    check({name, ".done_seen"}, W'(bus.done), W'(1));
    check({name, ".latency"}, W'(k), W'(exp_lat));
    check({name, ".busy_cycles"}, W'(busy_cnt), W'(exp_busy));
    check({name, ".busy_at_done"}, W'(bus.busy), W'(0));
    check({name, ".quotient"}, bus.quotient, eq);
    check({name, ".remainder"}, bus.remainder, er);
    check({name, ".div_by_zero"}, W'(bus.div_by_zero), W'(edbz));
  endtask

  // One idle cycle after a done: the pulse must have dropped and results held.
  task automatic idle_gap(input string name, input logic [W-1:0] eq, input logic [W-1:0] er);
    @(negedge ACLK);
    check({name, ".done_pulse_width"}, W'(bus.done), W'(0));
    check({name, ".quotient_held"}, bus.quotient, eq);
    check({name, ".remainder_held"}, bus.remainder, er);
  endtask

  initial begin
    logic [W-1:0] ra, rb, rq, rr;
    logic         rdbz;
    int           done_cnt;

    vecs[0] = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,    dbz: 1'b0, name: "basic_100_7"};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0,    dbz: 1'b0, name: "max_div_1"};
    vecs[2] = '{a: 32'd5,          b: 32'd9,          q: 32'd0,          r: 32'd5,    dbz: 1'b0, name: "small_5_9"};
    vecs[3] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  q: 32'd1,          r: 32'd0,    dbz: 1'b0, name: "max_div_max"};
    vecs[4] = '{a: 32'd1234,       b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd1234, dbz: 1'b1, name: "dbz_1234"};
    vecs[5] = '{a: 32'd10,         b: 32'd3,          q: 32'd3,          r: 32'd1,    dbz: 1'b0, name: "after_dbz_10_3"};

    ARESET = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(negedge ACLK);
    check("reset.busy", W'(bus.busy), W'(0));
    check("reset.done", W'(bus.done), W'(0));
    check("reset.div_by_zero", W'(bus.div_by_zero), W'(0));
    check("reset.quotient", bus.quotient, '0);
    check("reset.remainder", bus.remainder, '0);
    ARESET = 1'b0;
    @(negedge ACLK);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].name, 0, '0, '0);
      idle_gap(vecs[i].name, vecs[i].q, vecs[i].r);
    end

    // Start while busy must be ignored, not queued.
    run_op(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, "start_while_busy", 5, 32'd7, 32'd7);
    idle_gap("start_while_busy", 32'd100, 32'd0);
    done_cnt = 0;
    repeat (W + 4) begin
      @(negedge ACLK);
      if (bus.done) done_cnt++;
    end
    check("start_while_busy.no_second_done", W'(done_cnt), W'(0));

    // Back-to-back: second start issued in the DONE cycle of the first.
    run_op(32'd81, 32'd9, 32'd9, 32'd0, 1'b0, "b2b_first", 0, '0, '0);
    run_op(32'd50, 32'd8, 32'd6, 32'd2, 1'b0, "b2b_second", 0, '0, '0);
    idle_gap("b2b_second", 32'd6, 32'd2);

    // Reset mid-RUN discards the operation.
    bus.start = 1'b1; bus.dividend = 32'd1000; bus.divisor = 32'd10;
    @(negedge ACLK);
    bus.start = 1'b0;
    repeat (9) @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    check("midrun_reset.busy", W'(bus.busy), W'(0));
    check("midrun_reset.done", W'(bus.done), W'(0));
    check("midrun_reset.div_by_zero", W'(bus.div_by_zero), W'(0));
    check("midrun_reset.quotient", bus.quotient, '0);
    check("midrun_reset.remainder", bus.remainder, '0);
    done_cnt = 0;
    repeat (W + 4) begin
      @(negedge ACLK);
      if (bus.done || bus.busy) done_cnt++;
    end
    check("midrun_reset.no_activity", W'(done_cnt), W'(0));
    run_op(32'd9, 32'd4, 32'd2, 32'd1, 1'b0, "after_reset_9_4", 0, '0, '0);
    idle_gap("after_reset_9_4", 32'd2, 32'd1);

    // Random operations against the reference model, some back-to-back.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 7) == 0) ra = $urandom_range(0, 3);
      ref_div(ra, rb, rq, rr, rdbz);
      run_op(ra, rb, rq, rr, rdbz, $sformatf("rand%0d", i), 0, '0, '0);
      if ($urandom_range(0, 2) != 0) idle_gap($sformatf("rand%0d", i), rq, rr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/divider_core.md
# divider_core

Unsigned radix-2 restoring integer divider that sits directly downstream of the `divider` AXI4-Lite register slave. The slave's dividend, divisor and start registers drive the operand inputs. The quotient, remainder and status outputs feed back into the slave's read-only registers. One quotient bit is produced per clock, and the core accepts a new operation only while idle.

## Interface
- `DATA_WIDTH`, default 32: operand and result width in bits; must be at least 2.
- `ACLK` input 1: system clock; all logic is on the rising edge.
- `ARESET` input 1: one clock; reset is synchronous and active-high.
- `start` input 1: request a division; sampled only when `busy`=0.
- `dividend` input DATA_WIDTH: unsigned dividend; captured on the accepting edge.
- `divisor` input DATA_WIDTH: unsigned divisor; captured on the accepting edge.
- `busy` output 1: high while iterating.
- `done` output 1: one-cycle pulse; results are valid from this cycle.
- `quotient` output DATA_WIDTH: registered quotient; holds until the next `done`.
- `remainder` output DATA_WIDTH: registered remainder; holds until the next `done`.
- `div_by_zero` output 1: set with `done` when the captured divisor was 0; cleared on the next accepted start.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, `start`=1, divisor≠0:
  - Load the working quotient with the dividend and the partial remainder with 0.
  - Set the bit counter to DATA_WIDTH-1, clear `div_by_zero`, and go to RUN.
- IDLE, `start`=1, divisor=0:
  - Set quotient to all ones, remainder to the dividend and `div_by_zero`=1.
  - Go to DONE with no RUN cycles.
- RUN, each cycle:
  - Form the trial value {rem[W-2:0], q[W-1]} minus the divisor, computed at W+1 bits so the borrow is visible.
  - If there is no borrow, the new remainder is the trial difference and 1 is shifted into the quotient LSB.
  - Otherwise the remainder is the shifted value and 0 is shifted in.
  - The counter decrements; at counter=0 the final iteration is written to `quotient`/`remainder` and the state goes to DONE.
- DONE: `done`=1 for exactly one cycle.
  - `start` with `busy`=0 is accepted here too, exactly as from IDLE, so back-to-back operations are possible.
  - Otherwise go to IDLE.
- `start` while `busy`=1 is ignored; it is not queued.
- Operand inputs are don't-care except on the accepting edge.
- Output arithmetic is exact: quotient×divisor + remainder = dividend, with remainder < divisor.
- Reset (any state, including mid-RUN):
  - State goes to IDLE, and `busy`, `done`, `div_by_zero`, `quotient` and `remainder` go to 0.
  - Any in-flight operation is discarded, with no `done` pulse.

## Timing
- Latency for start high in cycle c (accepted on the edge ending c):
  - `busy`=1 in cycles c+1 … c+DATA_WIDTH.
  - `done`=1 with valid results in cycle c+DATA_WIDTH+1; this is c+33 for width 32.
- Divide-by-zero: `done` in cycle c+1, `busy` never asserts.
- Throughput: one result per DATA_WIDTH+1 cycles with back-to-back starts issued in the DONE cycle.
- `busy` and `done` are never high together.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted in cycle r: all outputs are 0 in cycle r+1; `start` is accepted again from cycle r+1 if reset is low.

## Test plan
- Basic: 100/7 → `done` at c+33 with quotient=14, remainder=2, `div_by_zero`=0; `busy` high for exactly 32 cycles.
- Extremes:
  - 0xFFFFFFFF/1 → quotient 0xFFFFFFFF, remainder 0.
  - 5/9 → quotient 0, remainder 5.
  - 0xFFFFFFFF/0xFFFFFFFF → quotient 1, remainder 0.
- Divide by zero: 1234/0 → `done` at c+1, quotient 0xFFFFFFFF, remainder 1234, `div_by_zero`=1. The next start 10/3 → `div_by_zero`=0, quotient 3, remainder 1.
- Start while busy: 1000/10 started, then `start` with 7/7 pulsed at c+5 → a single `done` at c+33 with quotient 100, remainder 0.
- Back-to-back: 81/9 started, then `start` with 50/8 held during the DONE cycle → second `done` exactly 33 cycles after the first, quotient 6, remainder 2.
- Reset mid-RUN: `ARESET` pulsed at c+10 → no `done` pulse, all outputs 0 the next cycle. A new start 9/4 afterwards → quotient 2, remainder 1 after 33 cycles.
